// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display path:
// segment patterns, digit positions and blink field selection.
package clock_disp_pkg;

  localparam int NUM_DIGITS = 6;

  localparam int DIG_SEC_U  = 0;
  localparam int DIG_SEC_T  = 1;
  localparam int DIG_MIN_U  = 2;
  localparam int DIG_MIN_T  = 3;
  localparam int DIG_HOUR_U = 4;
  localparam int DIG_HOUR_T = 5;

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef logic [3:0] bcd_t;

  // Value minus one is the digit pair index (idx[2:1]) that blinks
  typedef enum logic [1:0] {
    BLINK_NONE = 2'd0,
    BLINK_SEC  = 2'd1,
    BLINK_MIN  = 2'd2,
    BLINK_HOUR = 2'd3
  } blink_sel_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder (active-high),
// anything above 9 shows a dash.
module bcd_to_7seg
  import clock_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Six-digit multiplexed display scanner with per-frame snapshot and field blink.
// Optional LEADING_ZERO_BLANK_EN hides a zero hour tens digit.
module bcd_display_scanner
  import clock_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 1000,
  parameter int BLINK_DIV      = 12500000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hour_ten,
  input  logic [3:0] hour_unit,
  input  logic [3:0] minute_ten,
  input  logic [3:0] minute_unit,
  input  logic [3:0] second_ten,
  input  logic [3:0] second_unit,
  input  logic       mode_hour,
  input  logic       mode_minute,
  input  logic       mode_second,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic INV = (SEG_ACTIVE_LOW != 0);

  logic [RW-1:0] refresh_cnt;
  logic [BW-1:0] blink_cnt;
  logic [2:0]    idx;
  logic          blink_phase;
  logic          fresh;
  logic [NUM_DIGITS-1:0][3:0] snap;

  logic       refresh_tc;
  logic       blink_tc;
  logic       wrap;
  bcd_t       digit;
  logic [6:0] dec_seg;
  blink_sel_e blink_sel;
  logic       blink_blank;
  logic       lz_blank;
  logic       blank;
  logic [5:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  assign refresh_tc = refresh_cnt == RW'(REFRESH_DIV - 1);
  assign blink_tc   = blink_cnt == BW'(BLINK_DIV - 1);
  assign wrap       = refresh_tc && idx == 3'(NUM_DIGITS - 1);
  assign digit      = snap[idx];

  bcd_to_7seg u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

  always_comb begin
    blink_sel = BLINK_NONE;
    if (mode_hour)
      blink_sel = BLINK_HOUR;
    else if (mode_minute)
      blink_sel = BLINK_MIN;
    else if (mode_second)
      blink_sel = BLINK_SEC;
  end

  assign blink_blank = !blink_phase
                    && blink_sel != BLINK_NONE
                    && idx[2:1] == 2'(blink_sel) - 2'd1;

`ifdef LEADING_ZERO_BLANK_EN
  assign lz_blank = idx == 3'(DIG_HOUR_T)
                 && snap[DIG_HOUR_T] == 4'd0;
`else
  assign lz_blank = 1'b0;
`endif

  assign blank   = blink_blank | lz_blank;
  assign an_nxt  = blank ? 6'd0 : 6'd1 << idx;
  assign seg_nxt = blank ? SEG_OFF : dec_seg;
  assign dp_nxt  = !blank
                && (idx == 3'(DIG_MIN_U)
                 || idx == 3'(DIG_HOUR_U));

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      blink_cnt   <= '0;
      idx         <= '0;
      blink_phase <= 1'b1;
      fresh       <= 1'b1;
      snap        <= '0;
      an          <= {6{INV}};
      seg         <= {7{INV}};
      dp          <= INV;
    end else begin
      refresh_cnt <= refresh_tc ? '0 : refresh_cnt + 1'b1;
      if (refresh_tc)
        idx <= wrap ? 3'd0 : idx + 3'd1;
      blink_cnt <= blink_tc ? '0 : blink_cnt + 1'b1;
      if (blink_tc)
        blink_phase <= ~blink_phase;
      fresh <= 1'b0;
      // Whole-frame latch keeps a frame from mixing old and new time
      if (fresh || wrap)
        snap <= {hour_ten, hour_unit,
                 minute_ten, minute_unit,
                 second_ten, second_unit};
      an  <= an_nxt ^ {6{INV}};
      seg <= seg_nxt ^ {7{INV}};
      dp  <= dp_nxt ^ INV;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner: arithmetic reference
// model checked every cycle, plus directed literal expectations.
module tb_bcd_display_scanner;

  localparam int R = 4;
  localparam int B = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] hour_ten, hour_unit;
  logic [3:0] minute_ten, minute_unit;
  logic [3:0] second_ten, second_unit;
  logic       mode_hour, mode_minute, mode_second;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_display_scanner #(
    .REFRESH_DIV    (R),
    .BLINK_DIV      (B),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hour_ten    (hour_ten),
    .hour_unit   (hour_unit),
    .minute_ten  (minute_ten),
    .minute_unit (minute_unit),
    .second_ten  (second_ten),
    .second_unit (second_unit),
    .mode_hour   (mode_hour),
    .mode_minute (mode_minute),
    .mode_second (mode_second),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Reference model: k = clock edges since reset release
  int         k;
  logic [3:0] msnap [6];
  bit         mvalid = 0;
  logic [5:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  always @(posedge clk) begin : model
    int  i;
    int  p;
    bit  ph;
    bit  blank;
    if (rst) begin
      k       = 0;
      msnap   = '{default: 4'h0};
      exp_an  = 6'h3F;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
      mvalid  = 1;
    end else if (mvalid) begin
      i  = (k / R) % 6;
      ph = ((k / B) % 2) == 0;
      if (mode_hour) p = 2;
      else if (mode_minute) p = 1;
      else if (mode_second) p = 0;
      else p = -1;
      blank = !ph && (p == i / 2);
`ifdef LEADING_ZERO_BLANK_EN
      if (i == 5 && msnap[5] == 4'd0) blank = 1;
`endif
      exp_an  = blank ? 6'h3F : ~(6'd1 << i);
      exp_seg = blank ? 7'h7F : ~seg_of(msnap[i]);
      exp_dp  = !(!blank && (i == 2 || i == 4));
      if (k == 0 || (k + 1) % (6 * R) == 0)
        msnap = '{second_unit, second_ten, minute_unit,
                  minute_ten, hour_unit, hour_ten};
      k++;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("model_an", 32'(an), 32'(exp_an));
      check("model_seg", 32'(seg), 32'(exp_seg));
      check("model_dp", 32'(dp), 32'(exp_dp));
    end
  end

  task automatic set_time(input int h1, h0, m1, m0, s1, s0);
    hour_ten    = 4'(h1);
    hour_unit   = 4'(h0);
    minute_ten  = 4'(m1);
    minute_unit = 4'(m0);
    second_ten  = 4'(s1);
    second_unit = 4'(s0);
  endtask

  // Directed frame expectations: edge number, an, active-high seg, active-high dp
  int         pe   [8] = '{2, 5, 9, 10, 13, 17, 21, 34};
  logic [5:0] pan  [8] = '{6'h3E, 6'h3D, 6'h3B, 6'h3B,
                           6'h37, 6'h2F, 6'h1F, 6'h3B};
  logic [6:0] pseg [8] = '{7'h7D, 7'h6D, 7'h66, 7'h66,
                           7'h4F, 7'h5B, 7'h06, 7'h6F};
  logic       pdp  [8] = '{0, 0, 1, 1, 0, 1, 0, 1};

  initial begin : stim
    int  c01, c23, c5, c5z;
    bit  found;
    rst = 1'b1;
    set_time(0, 0, 0, 0, 0, 0);
    mode_hour = 0; mode_minute = 0; mode_second = 0;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'h3F);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);

    set_time(1, 2, 3, 4, 5, 6);
    rst = 1'b0;
    @(negedge clk);
    check("first_an", 32'(an), 32'h3E);
    for (int e = 2; e <= 34; e++) begin
      @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        if (pe[j] == e) begin
          check("frame_an", 32'(an), 32'(pan[j]));
          check("frame_seg", 32'(seg), 32'(pseg[j] ^ 7'h7F));
          check("frame_dp", 32'(dp), 32'(!pdp[j]));
        end
      end
      if (e == 5) minute_unit = 4'd9;
    end

    mode_minute = 1; mode_second = 1;
    c01 = 0; c23 = 0;
    repeat (96) begin
      @(negedge clk);
      if (an == 6'h3E || an == 6'h3D) c01++;
      if (an == 6'h3B || an == 6'h37) c23++;
    end
    check("blink_d01_count", 32'(c01), 32'd32);
    check("blink_d23_some_blank", 32'(c23 < 32), 32'd1);
    mode_minute = 0; mode_second = 0;

    hour_ten = 4'hC;
    repeat (48) @(negedge clk);
    found = 0;
    for (int t = 0; t < 30 && !found; t++) begin
      @(negedge clk);
      if (an == 6'h1F) begin
        found = 1;
        check("dash_seg", 32'(seg), 32'h3F);
      end
    end
    check("dash_found", 32'(found), 32'd1);

    hour_ten = 4'h0;
    repeat (48) @(negedge clk);
    c5 = 0; c5z = 0;
    repeat (48) begin
      @(negedge clk);
      if (an == 6'h1F) c5++;
      if (an == 6'h1F && seg == 7'h40) c5z++;
    end
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_hidden", 32'(c5), 32'd0);
`else
    check("lz_shown", 32'(c5), 32'd8);
    check("lz_zero_seg", 32'(c5z), 32'd8);
`endif

    found = 0;
    for (int t = 0; t < 30 && !found; t++) begin
      @(negedge clk);
      if (an == 6'h37) found = 1;
    end
    check("idx3_seen", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_an", 32'(an), 32'h3F);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_restart_an", 32'(an), 32'h3E);

    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0: second_unit = 4'($urandom_range(0, 15));
          1: second_ten  = 4'($urandom_range(0, 15));
          2: minute_unit = 4'($urandom_range(0, 15));
          3: minute_ten  = 4'($urandom_range(0, 15));
          4: hour_unit   = 4'($urandom_range(0, 15));
          default: hour_ten = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 39) == 0) begin
        mode_hour   = 1'($urandom_range(0, 1));
        mode_minute = 1'($urandom_range(0, 1));
        mode_second = 1'($urandom_range(0, 1));
      end
    end
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
